bus_arbiter_rr: RTL and testbench

//  Parametrised system-bus arbiter for N masters with round-robin fairness.

---
 rtl/bus_arb_pkg.sv | 24 ++
 rtl/bus_arbiter_rr_if.sv | 47 ++++
 rtl/rr_pick.sv | 30 +++
 rtl/bus_arbiter_rr.sv | 144 ++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and width helpers for the round-robin bus arbiter and the slave decoder.
package bus_arb_pkg;

    // Arbiter phases: wait for a request, shift in the slave address, own the bus.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        BUSY = 2'd2
    } arb_state_t;

    // Default slave-address width, also used by the downstream slave decoder.
    localparam int unsigned SLV_AW_DEFAULT = 2;

    // Width of a master index (bus_grant, round-robin pointer).
    function automatic int unsigned gw_of(input int unsigned n_mst);
        return (n_mst <= 2) ? 1 : $clog2(n_mst);
    endfunction

    // Width of a counter that runs from 0 to n-1.
    function automatic int unsigned cnt_w_of(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Master-side request/address signals and arbiter-side grant/slave-select signals.
// arb_timeout exists only when ARB_TIMEOUT_EN is defined.
interface bus_arbiter_rr_if
    import bus_arb_pkg::*;
#(
    parameter int unsigned N_MST  = 4,
    parameter int unsigned SLV_AW = SLV_AW_DEFAULT
);
    localparam int unsigned GW = gw_of(N_MST);

    logic [N_MST-1:0]  m_request;
    logic [N_MST-1:0]  m_slave_sel;
    logic [N_MST-1:0]  m_grant;
    logic [GW-1:0]     bus_grant;
    logic [SLV_AW-1:0] slave_sel;
    logic              slave_valid;
`ifdef ARB_TIMEOUT_EN
    logic              arb_timeout;
`endif

    // Requesting masters drive requests and serial address bits.
    modport master (
        output m_request,
        output m_slave_sel,
        input  m_grant,
        input  bus_grant,
        input  slave_sel,
        input  slave_valid
`ifdef ARB_TIMEOUT_EN
        , input arb_timeout
`endif
    );

    // The arbiter samples requests and drives grant and slave select.
    modport slave (
        input  m_request,
        input  m_slave_sel,
        output m_grant,
        output bus_grant,
        output slave_sel,
        output slave_valid
`ifdef ARB_TIMEOUT_EN
        , output arb_timeout
`endif
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int unsigned N_MST = 4,
    parameter int unsigned GW    = gw_of(N_MST)
) (
    input  logic [N_MST-1:0] req,
    input  logic [GW-1:0]    ptr,
    output logic [GW-1:0]    gnt_idx,
    output logic             any
);

    logic [GW-1:0] idx;

    // Scan ptr, ptr+1, ... modulo N_MST and keep the first requester found.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < N_MST; i++) begin
            idx = GW'((32'(ptr) + i) % N_MST);
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin system-bus arbiter for N_MST masters with serial slave-address capture.
// Optional feature macro: ARB_TIMEOUT_EN (forced release after MAX_HOLD BUSY cycles).
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int unsigned N_MST    = 4,
    parameter int unsigned SLV_AW   = SLV_AW_DEFAULT
`ifdef ARB_TIMEOUT_EN
    , parameter int unsigned MAX_HOLD = 64
`endif
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    bus_arbiter_rr_if.slave bus
);

    localparam int unsigned GW = gw_of(N_MST);
    localparam int unsigned BW = cnt_w_of(SLV_AW);

    arb_state_t        state;
    logic [GW-1:0]     rr_ptr;
    logic [GW-1:0]     owner;
    logic [N_MST-1:0]  grant_q;
    logic [SLV_AW-1:0] shift_q;
    logic [SLV_AW-1:0] sel_q;
    logic              valid_q;
    logic [BW-1:0]     bit_cnt;

    logic [N_MST-1:0]  req_eff;
    logic [GW-1:0]     pick_idx;
    logic              pick_any;
    logic              owner_req;
    logic              owner_bit;
    logic [GW-1:0]     ptr_after_owner;
    logic [SLV_AW-1:0] shift_next;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HW = cnt_w_of(MAX_HOLD);
    logic [HW-1:0]     hold_cnt;
    logic              timeout_q;
    logic [N_MST-1:0]  blocked;

    // A master released by timeout stays out of arbitration until it deasserts.
    assign req_eff = bus.m_request & ~blocked;
    assign bus.arb_timeout = timeout_q;
`else
    assign req_eff = bus.m_request;
`endif

    assign owner_req       = bus.m_request[owner];
    assign owner_bit       = bus.m_slave_sel[owner];
    assign ptr_after_owner = (owner == GW'(N_MST - 1)) ? '0 : owner + GW'(1);
    assign shift_next      = SLV_AW'({shift_q, owner_bit});

    assign bus.m_grant     = grant_q;
    assign bus.bus_grant   = owner;
    assign bus.slave_sel   = sel_q;
    assign bus.slave_valid = valid_q;

    rr_pick #(
        .N_MST (N_MST),
        .GW    (GW)
    ) u_pick (
        .req     (req_eff),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Arbitration FSM, address shift register and registered bus outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            grant_q <= '0;
            shift_q <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            bit_cnt <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
            blocked   <= '0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
            blocked   <= blocked & bus.m_request;
`endif
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_q <= N_MST'(1) << pick_idx;
                        owner   <= pick_idx;
                        bit_cnt <= '0;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (!owner_req) begin
                        grant_q <= '0;
                        rr_ptr  <= ptr_after_owner;
                        state   <= IDLE;
                    end else begin
                        shift_q <= shift_next;
                        if (bit_cnt == BW'(SLV_AW - 1)) begin
                            sel_q   <= shift_next;
                            valid_q <= 1'b1;
                            state   <= BUSY;
`ifdef ARB_TIMEOUT_EN
                            hold_cnt <= '0;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                BUSY: begin
                    if (!owner_req) begin
                        grant_q <= '0;
                        valid_q <= 1'b0;
                        rr_ptr  <= ptr_after_owner;
                        state   <= IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                        grant_q        <= '0;
                        valid_q        <= 1'b0;
                        rr_ptr         <= ptr_after_owner;
                        state          <= IDLE;
                        timeout_q      <= 1'b1;
                        blocked[owner] <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios, randomized transactions
// against a round-robin reference model, and a sweep over N_MST/SLV_AW variants.
module tb_bus_arbiter_rr;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned MH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bus_arbiter_rr_if #(.N_MST(4), .SLV_AW(2)) b4 ();
    bus_arbiter_rr_if #(.N_MST(8), .SLV_AW(3)) b8 ();
    bus_arbiter_rr_if #(.N_MST(2), .SLV_AW(1)) b2 ();

    bus_arbiter_rr #(
        .N_MST(4), .SLV_AW(2)
`ifdef ARB_TIMEOUT_EN
        , .MAX_HOLD(8)
`endif
    ) dut (.sys_clk(clk), .sys_rst(rst), .bus(b4));

    bus_arbiter_rr #(.N_MST(8), .SLV_AW(3)) dut8 (.sys_clk(clk), .sys_rst(rst), .bus(b8));
    bus_arbiter_rr #(.N_MST(2), .SLV_AW(1)) dut2 (.sys_clk(clk), .sys_rst(rst), .bus(b2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all four main outputs of the N=4 instance.
    task automatic chk4(input string tag, input logic [31:0] g, input logic [31:0] bg,
                        input logic [31:0] sel, input logic [31:0] v);
        chk({tag, "_grant"}, 32'(b4.m_grant), g);
        chk({tag, "_busgrant"}, 32'(b4.bus_grant), bg);
        chk({tag, "_sel"}, 32'(b4.slave_sel), sel);
        chk({tag, "_valid"}, 32'(b4.slave_valid), v);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int          exp_order [4];
        int          rr;
        int          w;
        int          addr;
        int          last_sel;
        int          abat;
        int          blen;
        bit          ab;
        bit          aborted;
        logic [3:0]  req;
        logic [3:0]  r;
        logic [3:0]  s;
        logic [1:0]  ix;
        logic [7:0]  s8;
        logic [2:0]  k8;
        logic [1:0]  s2;

        exp_order = '{0, 1, 3, 0};
        b4.m_request = '0; b4.m_slave_sel = '0;
        b8.m_request = '0; b8.m_slave_sel = '0;
        b2.m_request = '0; b2.m_slave_sel = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        chk4("reset", 0, 0, 0, 0);
`ifdef ARB_TIMEOUT_EN
        chk("reset_timeout", 32'(b4.arb_timeout), 0);
`endif

        // Single master m1 sends address 2'b10
        b4.m_request = 4'b0010;
        tick();
        chk4("single_grant", 4'b0010, 1, 0, 0);
        b4.m_slave_sel = 4'b0010;
        tick();
        chk4("single_bit1", 4'b0010, 1, 0, 0);
        b4.m_slave_sel = 4'b0000;
        tick();
        chk4("single_addr", 4'b0010, 1, 2, 1);
        b4.m_request = 4'b0000;
        tick();
        chk4("single_drop", 0, 1, 2, 0);

        // Abort: m2 drops after its first address bit; pointer moves to m3
        b4.m_request = 4'b0100;
        tick();
        chk4("abort_grant", 4'b0100, 2, 2, 0);
        b4.m_slave_sel = 4'b0100;
        tick();
        b4.m_request = 4'b0000;
        tick();
        chk4("abort", 0, 2, 2, 0);
        b4.m_request = 4'b1111;
        b4.m_slave_sel = 4'b0000;
        tick();
        chk4("abort_next", 4'b1000, 3, 2, 0);
        tick();
        b4.m_slave_sel = 4'b1000;
        tick();
        chk4("abort_next_addr", 4'b1000, 3, 1, 1);
        b4.m_request = 4'b0000;
        tick();
        chk4("abort_next_drop", 0, 3, 1, 0);

        // Reset while m1 owns the bus in BUSY, request still held
        b4.m_request = 4'b0010;
        b4.m_slave_sel = 4'b0010;
        tick();
        tick();
        tick();
        tick();
        chk4("prerst_busy", 4'b0010, 1, 3, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk4("rst_busy", 0, 0, 0, 0);
        tick();
        chk4("rst_regrant", 4'b0010, 1, 0, 0);
        b4.m_request = 4'b0000;
        b4.m_slave_sel = 4'b0000;
        tick();
        chk4("rst_regrant_abort", 0, 1, 0, 0);

        // Contention 4'b1011, each owner releases after 3 BUSY cycles
        pulse_reset();
        for (int t = 0; t < 4; t++) begin
            b4.m_request = 4'b1011;
            tick();
            chk("contend_grant", 32'(b4.m_grant), 32'(1) << exp_order[t]);
            chk("contend_busgrant", 32'(b4.bus_grant), 32'(exp_order[t]));
            tick();
            tick();
            chk("contend_valid", 32'(b4.slave_valid), 1);
            tick();
            tick();
            b4.m_request[exp_order[t]] = 1'b0;
            tick();
            chk("contend_idle", 32'(b4.m_grant), 0);
        end
        b4.m_request = 4'b0000;

`ifdef ARB_TIMEOUT_EN
        // Timeout: m0 holds too long, pending m2 is granted next
        pulse_reset();
        b4.m_request = 4'b0101;
        tick();
        chk("to_grant0", 32'(b4.m_grant), 4'b0001);
        tick();
        tick();
        chk("to_valid", 32'(b4.slave_valid), 1);
        for (int i = 0; i < int'(MH) - 1; i++) begin
            tick();
            chk("to_hold", 32'(b4.m_grant), 4'b0001);
            chk("to_nopulse", 32'(b4.arb_timeout), 0);
        end
        tick();
        chk("to_release", 32'(b4.m_grant), 0);
        chk("to_release_valid", 32'(b4.slave_valid), 0);
        chk("to_pulse", 32'(b4.arb_timeout), 1);
        tick();
        chk("to_pulse_end", 32'(b4.arb_timeout), 0);
        chk("to_grant2", 32'(b4.m_grant), 4'b0100);
        b4.m_request = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("to_locked", 32'(b4.m_grant), 0);
        end
        b4.m_request = 4'b0000;
        tick();
        b4.m_request = 4'b0001;
        tick();
        chk("to_rerequest", 32'(b4.m_grant), 4'b0001);
        b4.m_request = 4'b0000;
        tick();
`endif

        // Randomized transactions against a round-robin reference model
        pulse_reset();
        rr = 0;
        last_sel = 0;
        for (int n = 0; n < 80; n++) begin
            req = 4'($urandom_range(1, 15));
            b4.m_request = req;
            b4.m_slave_sel = 4'($urandom);
            w = 0;
            for (int i = N - 1; i >= 0; i--) begin
                ix = 2'((rr + i) % N);
                if (req[ix]) w = (rr + i) % N;
            end
            tick();
            chk4("rnd_grant", 32'(1) << w, w, last_sel, 0);
            addr = int'($urandom_range(0, (1 << AW) - 1));
            ab = ($urandom_range(0, 3) == 0);
            abat = int'($urandom_range(0, AW - 1));
            aborted = 1'b0;
            for (int b = 0; b < int'(AW); b++) begin
                s = 4'($urandom);
                s[w] = 1'((addr >> (int'(AW) - 1 - b)) & 1);
                r = 4'($urandom);
                r[w] = !(ab && b == abat);
                b4.m_slave_sel = s;
                b4.m_request = r;
                tick();
                if (ab && b == abat) begin
                    chk4("rnd_abort", 0, w, last_sel, 0);
                    aborted = 1'b1;
                    break;
                end
                chk("rnd_addr_grant", 32'(b4.m_grant), 32'(1) << w);
                chk("rnd_addr_valid", 32'(b4.slave_valid), (b == int'(AW) - 1) ? 1 : 0);
            end
            rr = (w + 1) % N;
            if (!aborted) begin
                last_sel = addr;
                chk("rnd_sel", 32'(b4.slave_sel), 32'(addr));
                blen = int'($urandom_range(0, 4));
                for (int c = 0; c < blen; c++) begin
                    r = 4'($urandom);
                    r[w] = 1'b1;
                    b4.m_request = r;
                    b4.m_slave_sel = 4'($urandom);
                    tick();
                    chk4("rnd_busy", 32'(1) << w, w, addr, 1);
                end
                r = 4'($urandom);
                r[w] = 1'b0;
                b4.m_request = r;
                tick();
                chk4("rnd_release", 0, w, addr, 0);
            end
        end
        b4.m_request = 4'b0000;

        // Sweep: N_MST=8/SLV_AW=3 and N_MST=2/SLV_AW=1, master k sends k mod 2^SLV_AW
        pulse_reset();
        for (int k = 0; k < 8; k++) begin
            k8 = 3'(k);
            b8.m_request = 8'(1) << k8;
            tick();
            chk("sw8_grant", 32'(b8.m_grant), 32'(1) << k);
            for (int b = 0; b < 3; b++) begin
                s8 = '0;
                s8[k8] = 1'(((k % 8) >> (2 - b)) & 1);
                b8.m_slave_sel = s8;
                tick();
            end
            chk("sw8_sel", 32'(b8.slave_sel), 32'(k % 8));
            chk("sw8_busgrant", 32'(b8.bus_grant), 32'(k));
            chk("sw8_valid", 32'(b8.slave_valid), 1);
            b8.m_request = '0;
            tick();
            chk("sw8_drop", 32'(b8.m_grant), 0);
        end
        for (int k = 0; k < 2; k++) begin
            b2.m_request = 2'(1) << k;
            tick();
            chk("sw2_grant", 32'(b2.m_grant), 32'(1) << k);
            s2 = '0;
            s2[k] = 1'(k % 2);
            b2.m_slave_sel = s2;
            tick();
            chk("sw2_sel", 32'(b2.slave_sel), 32'(k % 2));
            chk("sw2_busgrant", 32'(b2.bus_grant), 32'(k));
            chk("sw2_valid", 32'(b2.slave_valid), 1);
            b2.m_request = '0;
            tick();
            chk("sw2_drop", 32'(b2.m_grant), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
